// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake on both sides,
// an internal accumulator and a saturating signed-overflow event counter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand beat handshake (a, b, op, oe)
//   out_valid/out_ready      result beat handshake
//   y                        result, forced to 0 when the beat's oe=0
//   carry/overflow/parity/zero   result flags (computed on ungated result)
//   greater/is_eq/less       unsigned compare of the beat's a vs b
//   acc                      current accumulator value
//   ovf_count                saturating count of delivered beats with overflow=1
module alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             oe,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             parity,
  output logic             zero,
  output logic             greater,
  output logic             is_eq,
  output logic             less,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_ACC = 3'b110,
    OP_CLR = 3'b111
  } op_e;

  // Stage 1 operand registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s1_oe;

  // Holds in_ready low for the first cycle after reset is released
  logic             rdy_q;

  logic             s2_adv;
  logic             s1_adv;
  logic             s1_load;

  // Stage 1 combinational results
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] r;
  logic             r_carry;
  logic             r_ovf;
  logic [WIDTH-1:0] acc_nxt;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s2_adv;
  assign in_ready = rdy_q && !rst && (!s1_valid || s1_adv);
  assign s1_load  = in_valid && in_ready;

  // Result, carry, overflow and accumulator next value from the S1 beat
  always_comb begin
    ext     = '0;
    r       = '0;
    r_carry = 1'b0;
    r_ovf   = 1'b0;
    acc_nxt = acc;
    unique case (s1_op)
      OP_ADD: begin
        ext     = {1'b0, s1_a} + {1'b0, s1_b};
        r       = ext[MSB:0];
        r_carry = ext[WIDTH];
        r_ovf   = (s1_a[MSB] == s1_b[MSB]) && (r[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (a < b)
        ext     = {1'b0, s1_a} - {1'b0, s1_b};
        r       = ext[MSB:0];
        r_carry = ext[WIDTH];
        r_ovf   = (s1_a[MSB] != s1_b[MSB]) && (r[MSB] != s1_a[MSB]);
      end
      OP_AND: r = s1_a & s1_b;
      OP_OR:  r = s1_a | s1_b;
      OP_XOR: r = s1_a ^ s1_b;
      OP_SHL: begin
        r       = s1_a << 1;
        r_carry = s1_a[MSB];
      end
      OP_ACC: begin
        ext     = {1'b0, acc} + {1'b0, s1_a};
        r       = ext[MSB:0];
        r_carry = ext[WIDTH];
        r_ovf   = (acc[MSB] == s1_a[MSB]) && (r[MSB] != acc[MSB]);
        acc_nxt = r;
      end
      OP_CLR: acc_nxt = '0;
      default: ;
    endcase
  end

  // Stage 1 register and reset-release flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_oe    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= op_e'(op);
        s1_oe    <= oe;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 output register and accumulator; only moves when S2 may advance
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      parity    <= 1'b0;
      zero      <= 1'b0;
      greater   <= 1'b0;
      is_eq     <= 1'b0;
      less      <= 1'b0;
      acc       <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y        <= s1_oe ? r : '0;
        carry    <= r_carry;
        overflow <= r_ovf;
        parity   <= ^r;
        zero     <= (r == '0);
        greater  <= (s1_a > s1_b);
        is_eq    <= (s1_a == s1_b);
        less     <= (s1_a < s1_b);
        acc      <= acc_nxt;
      end
    end
  end

  // Overflow event counter, counted at delivery and saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && overflow && (ovf_count != '1)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule
